rti_vec_engine: RTL and testbench
=================================

Name: rti_vec_engine

Overview:
- Parametrised 3-D vector arithmetic engine for the ray/triangle intersection datapath. Generalises the earlier fixed six-lane sequencer.
- Accepts one tagged vector operation (SUB, DOT, CROSS, SCALE) over a valid/ready handshake.
- Time-multiplexes NUM_MULS pipelined multiplier lanes, then reduces the products.
- Returns a full-precision signed result over a second valid/ready handshake.
- Intersection controllers issue their vector-difference, normal, dot-product and barycentric steps through this block.

Parameters:
- DATA_W, 32: operand component width, signed two's complement.
- NUM_MULS, 3: multiplier lanes. Legal values are 1, 2, 3 and 6; any other value is an elaboration error.
- MUL_LAT, 2: multiplier pipeline depth in cycles, at least 1.
- TAG_W, 5: width of the pass-through tag.
- RES_W, 2*DATA_W+2: result component width (derived).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- in_valid_i  in  1  operation request.
- in_ready_o  out  1  engine can accept an operation.
- op_i  in  2  operation: 00 SUB, 01 DOT, 10 CROSS, 11 SCALE.
- a_i  in  3*DATA_W  vector A; x in the LSBs.
- b_i  in  3*DATA_W  vector B; SCALE uses only b.x.
- tag_i  in  TAG_W  request tag.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- res_o  out  3*RES_W  result vector; x in the LSBs.
- tag_o  out  TAG_W  tag of the result.
- busy_o  out  1  operation in flight or result pending.

Behaviour:
- Clocking and reset: one clock, clk_i. rst_ni is asynchronous and active-low.
- Reset values: out_valid_o=0, busy_o=0, res_o=0, tag_o=0, in_ready_o=0. All state returns to IDLE.
- After reset is released, in_ready_o=1 from the first cycle.
- Reset asserted mid-operation aborts the operation. No result is produced and the in-flight multiplier pipe is cleared.
- Accept: an operation is accepted on the edge where in_valid_i && in_ready_o. On that edge op, a, b and tag are registered.
- in_ready_o = (state==IDLE). Only one operation is in flight at a time.
- States:
  - IDLE: wait for accept, then go to ISSUE (or to REDUCE for SUB).
  - ISSUE: issue one wave of up to NUM_MULS products per cycle. Go to DRAIN after the last wave.
  - DRAIN: wait until the last wave has spent MUL_LAT cycles in the multiplier pipe, then go to REDUCE.
  - REDUCE: one cycle of add/subtract, registers res/tag, then OUT.
  - OUT: out_valid_o=1. On out_ready_i go to IDLE.
- Products required (P) and waves issued (W = ceil(P/NUM_MULS)):
  - SUB: P=0.
  - DOT: ax*bx, ay*by, az*bz (P=3).
  - CROSS: ay*bz, az*by, az*bx, ax*bz, ax*by, ay*bx (P=6).
  - SCALE: ax*bx, ay*bx, az*bx (P=3).
- Product issue order is fixed: ascending index as listed above.
- Latency: out_valid_o rises W+MUL_LAT+1 cycles after the accepting edge. SUB takes exactly 1 cycle.
- Arithmetic is exact and has no saturation. Products are 2*DATA_W bits, and all results are sign-extended to RES_W:
  - SUB: res = a-b per component.
  - DOT: res.x = sum of the three products; res.y = res.z = 0.
  - CROSS: (ay*bz-az*by, az*bx-ax*bz, ax*by-ay*bx).
  - SCALE: per-component products.
- Output handshake: res_o and tag_o are stable while out_valid_o && !out_ready_i.
- The result is retired on the edge with out_valid_o && out_ready_i.
- in_ready_o returns to 1 in the following cycle. There is no back-to-back overlap.
- in_valid_i while in_ready_o=0 is ignored and no state changes.
- busy_o = (state != IDLE).
- tag_o equals the tag captured at accept.

Test Plan:
Default configuration (DATA_W=32, NUM_MULS=3, MUL_LAT=2) unless noted.
- SUB a=(5,-3,7), b=(2,4,-1), tag=3 -> res=(3,-7,8), tag_o=3, out_valid 1 cycle after accept.
- DOT a=(1,2,3), b=(4,5,6) -> res=(32,0,0), out_valid 4 cycles after accept.
- CROSS a=(1,0,0), b=(0,1,0) -> res=(0,0,1):
  - latency 5 with the default configuration;
  - latency 4 with NUM_MULS=6;
  - latency 9 with NUM_MULS=1.
- SCALE a=(2,-3,4), b.x=-5 -> res=(-10,15,-20).
- Extremes: DOT a=b=(-2^31,-2^31,-2^31) -> res.x = 3*2^62 exact. CROSS a=(2^31-1,0,0), b=(0,-2^31,0) -> res.z = -(2^31-1)*2^31.
- Backpressure and reset:
  - Hold out_ready_i=0 for 10 cycles: res/tag stay stable, in_ready_o stays 0, and a new in_valid_i is ignored.
  - Raise out_ready_i: in_ready_o is 1 in the next cycle.
  - Assert rst_ni mid-CROSS: out_valid_o is 0 immediately, and no stale result appears after release.

Source files
------------

// File: rtl/rti_vec_engine.sv
// rti_vec_engine
// ----------------------------------------------------------------------------
// 3-D vector arithmetic engine used by the ray/triangle intersection datapath.
// Accepts one tagged operation at a time (SUB, DOT, CROSS, SCALE). It issues
// the required products over NUM_MULS pipelined multiplier lanes, then reduces
// them in one add/subtract cycle. It returns a full-precision signed result.
//
// Handshakes: a transfer happens on the rising clk_i edge where valid and ready
// are both high. in_ready_o depends only on engine state and never on
// in_valid_i. Once out_valid_o is raised, res_o/tag_o hold until the consumer
// takes them.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   in_valid_i/ready_o   operation request handshake
//   op_i                 00 SUB, 01 DOT, 10 CROSS, 11 SCALE
//   a_i, b_i             operand vectors, x component in the LSBs
//   tag_i                request tag, returned unchanged on tag_o
//   out_valid_o/ready_i  result handshake
//   res_o                result vector (RES_W per component), x in the LSBs
//   tag_o                tag of the result
//   busy_o               operation in flight or result pending
//   state_o              FSM state (debug visibility)
// ----------------------------------------------------------------------------
module rti_vec_engine #(
    parameter int DATA_W   = 32,
    parameter int NUM_MULS = 3,
    parameter int MUL_LAT  = 2,
    parameter int TAG_W    = 5,
    parameter int RES_W    = 2*DATA_W+2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [1:0]           op_i,
    input  logic [3*DATA_W-1:0]  a_i,
    input  logic [3*DATA_W-1:0]  b_i,
    input  logic [TAG_W-1:0]     tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [3*RES_W-1:0]   res_o,
    output logic [TAG_W-1:0]     tag_o,
    output logic                 busy_o,
    output logic [2:0]           state_o
);

    localparam int PROD_W  = 2*DATA_W;
    localparam int W_DOT   = (3 + NUM_MULS - 1) / NUM_MULS;
    localparam int W_CROSS = (6 + NUM_MULS - 1) / NUM_MULS;
    localparam int CNT_W   = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    localparam logic [1:0] OP_SUB   = 2'b00;
    localparam logic [1:0] OP_DOT   = 2'b01;
    localparam logic [1:0] OP_CROSS = 2'b10;
    localparam logic [1:0] OP_SCALE = 2'b11;

    // Component selectors for the six CROSS products, product 0 in the LSBs.
    // Order: ay*bz, az*by, az*bx, ax*bz, ax*by, ay*bx.
    localparam logic [11:0] CROSS_A = {2'd1, 2'd0, 2'd0, 2'd2, 2'd2, 2'd1};
    localparam logic [11:0] CROSS_B = {2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

    if (!(NUM_MULS == 1 || NUM_MULS == 2 || NUM_MULS == 3 || NUM_MULS == 6)) begin : g_bad_num_muls
        $error("rti_vec_engine: NUM_MULS must be 1, 2, 3 or 6");
    end
    if (MUL_LAT < 1) begin : g_bad_mul_lat
        $error("rti_vec_engine: MUL_LAT must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_DRAIN  = 3'd2,
        S_REDUCE = 3'd3,
        S_OUT    = 3'd4
    } state_e;

    state_e                     state_q, state_d;
    logic [2:0]                 wave_q, wave_d;
    logic [CNT_W-1:0]           drain_q, drain_d;
    logic [1:0]                 op_q;
    logic [3*DATA_W-1:0]        a_q, b_q;
    logic [TAG_W-1:0]           tag_q;
    logic [3*RES_W-1:0]         res_q;
    logic [TAG_W-1:0]           tag_out_q;

    logic signed [PROD_W-1:0]   pipe_q [MUL_LAT][NUM_MULS];
    logic                       pipe_vld_q [MUL_LAT];
    logic [2:0]                 pipe_wave_q [MUL_LAT];
    logic signed [PROD_W-1:0]   prod_q [6];

    logic                       accept;
    logic [2:0]                 last_wave;
    logic [2:0]                 lidx  [NUM_MULS];
    logic [1:0]                 sel_a [NUM_MULS];
    logic [1:0]                 sel_b [NUM_MULS];
    logic                       lane_en [NUM_MULS];
    logic signed [PROD_W-1:0]   mul_a [NUM_MULS];
    logic signed [PROD_W-1:0]   mul_b [NUM_MULS];
    logic signed [RES_W-1:0]    rx, ry, rz;

    // Pick one component of a vector, sign-extended to product width so the
    // multiply below is a full-width signed product.
    function automatic logic signed [PROD_W-1:0] comp(input logic [3*DATA_W-1:0] v,
                                                      input logic [1:0] sel);
        case (sel)
            2'd0:    return {{DATA_W{v[DATA_W-1]}},   v[DATA_W-1:0]};
            2'd1:    return {{DATA_W{v[2*DATA_W-1]}}, v[2*DATA_W-1:DATA_W]};
            default: return {{DATA_W{v[3*DATA_W-1]}}, v[3*DATA_W-1:2*DATA_W]};
        endcase
    endfunction

    function automatic logic signed [RES_W-1:0] ext_d(input logic [DATA_W-1:0] x);
        return {{(RES_W-DATA_W){x[DATA_W-1]}}, x};
    endfunction

    function automatic logic signed [RES_W-1:0] ext_p(input logic [PROD_W-1:0] x);
        return {{(RES_W-PROD_W){x[PROD_W-1]}}, x};
    endfunction

    assign in_ready_o  = rst_ni && (state_q == S_IDLE);
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = (state_q == S_OUT);
    assign busy_o      = (state_q != S_IDLE);
    assign state_o     = state_q;
    assign res_o       = res_q;
    assign tag_o       = tag_out_q;
    assign last_wave   = (op_q == OP_CROSS) ? 3'(W_CROSS - 1) : 3'(W_DOT - 1);

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        wave_d  = wave_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (op_i == OP_SUB) ? S_REDUCE : S_ISSUE;
                    wave_d  = 3'd0;
                end
            end
            S_ISSUE: begin
                if (wave_q == last_wave) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end else begin
                    wave_d = wave_q + 3'd1;
                end
            end
            S_DRAIN: begin
                // Leave once the last wave has spent MUL_LAT cycles in the pipe.
                if (drain_q == CNT_W'(MUL_LAT - 1)) begin
                    state_d = S_REDUCE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_REDUCE: state_d = S_OUT;
            S_OUT: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            wave_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            wave_q  <= wave_d;
            drain_q <= drain_d;
        end
    end

    // ---------------- Operand capture ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q  <= OP_SUB;
            a_q   <= '0;
            b_q   <= '0;
            tag_q <= '0;
        end else if (accept) begin
            op_q  <= op_i;
            a_q   <= a_i;
            b_q   <= b_i;
            tag_q <= tag_i;
        end
    end

    // ---------------- Lane operand selection ----------------
    // Lane l of wave w computes product index w*NUM_MULS+l. Lanes past the
    // last product of the operation are fed zeros.
    always_comb begin
        for (int l = 0; l < NUM_MULS; l++) begin
            lidx[l]    = 3'(int'(wave_q) * NUM_MULS + l);
            sel_a[l]   = 2'd0;
            sel_b[l]   = 2'd0;
            lane_en[l] = 1'b0;
            case (op_q)
                OP_DOT: begin
                    sel_a[l]   = lidx[l][1:0];
                    sel_b[l]   = lidx[l][1:0];
                    lane_en[l] = (lidx[l] < 3'd3);
                end
                OP_CROSS: begin
                    sel_a[l]   = CROSS_A[{lidx[l], 1'b0} +: 2];
                    sel_b[l]   = CROSS_B[{lidx[l], 1'b0} +: 2];
                    lane_en[l] = 1'b1;
                end
                OP_SCALE: begin
                    sel_a[l]   = lidx[l][1:0];
                    sel_b[l]   = 2'd0;
                    lane_en[l] = (lidx[l] < 3'd3);
                end
                default: lane_en[l] = 1'b0;
            endcase
            mul_a[l] = lane_en[l] ? comp(a_q, sel_a[l]) : '0;
            mul_b[l] = lane_en[l] ? comp(b_q, sel_b[l]) : '0;
        end
    end

    // ---------------- Multiplier pipe and product collection ----------------
    // Each stage carries the wave index so the pipe output knows which product
    // slots it fills.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < MUL_LAT; s++) begin
                pipe_vld_q[s]  <= 1'b0;
                pipe_wave_q[s] <= '0;
                for (int l = 0; l < NUM_MULS; l++) begin
                    pipe_q[s][l] <= '0;
                end
            end
            for (int p = 0; p < 6; p++) begin
                prod_q[p] <= '0;
            end
        end else begin
            pipe_vld_q[0]  <= (state_q == S_ISSUE);
            pipe_wave_q[0] <= wave_q;
            for (int l = 0; l < NUM_MULS; l++) begin
                pipe_q[0][l] <= mul_a[l] * mul_b[l];
            end
            for (int s = 1; s < MUL_LAT; s++) begin
                pipe_vld_q[s]  <= pipe_vld_q[s-1];
                pipe_wave_q[s] <= pipe_wave_q[s-1];
                for (int l = 0; l < NUM_MULS; l++) begin
                    pipe_q[s][l] <= pipe_q[s-1][l];
                end
            end
            if (pipe_vld_q[MUL_LAT-1]) begin
                for (int l = 0; l < NUM_MULS; l++) begin
                    prod_q[3'(int'(pipe_wave_q[MUL_LAT-1]) * NUM_MULS + l)] <= pipe_q[MUL_LAT-1][l];
                end
            end
        end
    end

    // ---------------- Reduction ----------------
    always_comb begin
        rx = '0;
        ry = '0;
        rz = '0;
        case (op_q)
            OP_SUB: begin
                rx = ext_d(a_q[DATA_W-1:0])            - ext_d(b_q[DATA_W-1:0]);
                ry = ext_d(a_q[2*DATA_W-1:DATA_W])     - ext_d(b_q[2*DATA_W-1:DATA_W]);
                rz = ext_d(a_q[3*DATA_W-1:2*DATA_W])   - ext_d(b_q[3*DATA_W-1:2*DATA_W]);
            end
            OP_DOT: begin
                rx = ext_p(prod_q[0]) + ext_p(prod_q[1]) + ext_p(prod_q[2]);
            end
            OP_CROSS: begin
                rx = ext_p(prod_q[0]) - ext_p(prod_q[1]);
                ry = ext_p(prod_q[2]) - ext_p(prod_q[3]);
                rz = ext_p(prod_q[4]) - ext_p(prod_q[5]);
            end
            default: begin
                rx = ext_p(prod_q[0]);
                ry = ext_p(prod_q[1]);
                rz = ext_p(prod_q[2]);
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_q     <= '0;
            tag_out_q <= '0;
        end else if (state_q == S_REDUCE) begin
            res_q     <= {rz, ry, rx};
            tag_out_q <= tag_q;
        end
    end

endmodule

// File: tb/tb_rti_vec_engine.sv
module tb_rti_vec_engine;

  localparam int DW = 32;
  localparam int NM = 3;
  localparam int ML = 2;
  localparam int TW = 5;
  localparam int RW = 2*DW+2;

  localparam logic [1:0] OP_SUB   = 2'b00;
  localparam logic [1:0] OP_DOT   = 2'b01;
  localparam logic [1:0] OP_CROSS = 2'b10;
  localparam logic [1:0] OP_SCALE = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_valid6, in_valid1, out_ready;
  logic [1:0] op;
  logic [3*DW-1:0] a, b;
  logic [TW-1:0] tag;

  logic in_ready, out_valid, busy;
  logic [3*RW-1:0] res;
  logic [TW-1:0] tag_o;
  logic [2:0] state;

  logic in_ready6, out_valid6, busy6;
  logic [3*RW-1:0] res6;
  logic [TW-1:0] tag6;
  logic [2:0] state6;

  logic in_ready1, out_valid1, busy1;
  logic [3*RW-1:0] res1;
  logic [TW-1:0] tag1;
  logic [2:0] state1;

  int checks = 0;
  int errors = 0;

  logic [3*RW-1:0] exp_q[$];
  logic [TW-1:0]   exp_tag_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1, "watchdog");
  end

  rti_vec_engine #(.DATA_W(DW), .NUM_MULS(NM), .MUL_LAT(ML), .TAG_W(TW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .a_i(a), .b_i(b), .tag_i(tag), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .res_o(res), .tag_o(tag_o), .busy_o(busy), .state_o(state)
  );

  rti_vec_engine #(.DATA_W(DW), .NUM_MULS(6), .MUL_LAT(ML), .TAG_W(TW)) dut6 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid6), .in_ready_o(in_ready6),
    .op_i(op), .a_i(a), .b_i(b), .tag_i(tag), .out_valid_o(out_valid6),
    .out_ready_i(1'b1), .res_o(res6), .tag_o(tag6), .busy_o(busy6), .state_o(state6)
  );

  rti_vec_engine #(.DATA_W(DW), .NUM_MULS(1), .MUL_LAT(ML), .TAG_W(TW)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid1), .in_ready_o(in_ready1),
    .op_i(op), .a_i(a), .b_i(b), .tag_i(tag), .out_valid_o(out_valid1),
    .out_ready_i(1'b1), .res_o(res1), .tag_o(tag1), .busy_o(busy1), .state_o(state1)
  );

  // ---------------- reference model ----------------
  function automatic logic [3*DW-1:0] vec(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return {z, y, x};
  endfunction

  function automatic logic [3*RW-1:0] vres(input longint x, input longint y, input longint z);
    return {{(RW-64){z[63]}}, z, {(RW-64){y[63]}}, y, {(RW-64){x[63]}}, x};
  endfunction

  function automatic logic [3*RW-1:0] ref_model(input logic [1:0] o, input logic [3*DW-1:0] av,
                                                input logic [3*DW-1:0] bv);
    logic signed [RW-1:0] x[3];
    logic signed [RW-1:0] y[3];
    logic signed [RW-1:0] r[3];
    logic [DW-1:0] t;
    for (int i = 0; i < 3; i++) begin
      t = av[i*DW +: DW];
      x[i] = {{(RW-DW){t[DW-1]}}, t};
      t = bv[i*DW +: DW];
      y[i] = {{(RW-DW){t[DW-1]}}, t};
      r[i] = '0;
    end
    case (o)
      OP_SUB:   for (int i = 0; i < 3; i++) r[i] = x[i] - y[i];
      OP_DOT:   r[0] = x[0]*y[0] + x[1]*y[1] + x[2]*y[2];
      OP_CROSS: begin
        r[0] = x[1]*y[2] - x[2]*y[1];
        r[1] = x[2]*y[0] - x[0]*y[2];
        r[2] = x[0]*y[1] - x[1]*y[0];
      end
      default:  for (int i = 0; i < 3; i++) r[i] = x[i] * y[0];
    endcase
    return {r[2], r[1], r[0]};
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input int nm);
    int p;
    if (o == OP_SUB) return 1;
    p = (o == OP_CROSS) ? 6 : 3;
    return (p + nm - 1) / nm + ML + 1;
  endfunction

  function automatic logic [DW-1:0] rand_comp();
    case ($urandom_range(0, 3))
      0:       return DW'($urandom_range(0, 20)) - DW'(10);
      1:       return DW'($urandom);
      2:       return 32'h8000_0000;
      default: return 32'h7fff_ffff;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] o, input logic [3*DW-1:0] av, input logic [3*DW-1:0] bv,
                       input logic [TW-1:0] t);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: in_ready=%b required 1 within 50 cycles", in_ready);
    end
    op = o; a = av; b = bv; tag = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int bound, output int lat, output bit seen);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < bound) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid === 1'b1) seen = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b exp 0", in_ready); end
    checks++; if (res !== '0) begin errors++; $display("FAIL rst_res: got %h exp 0", res); end
    checks++; if (tag_o !== '0) begin errors++; $display("FAIL rst_tag: got %h exp 0", tag_o); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready: got %b exp 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rel_busy: got %b exp 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [1:0]       ops[6];
    logic [3*DW-1:0]  av[6];
    logic [3*DW-1:0]  bv[6];
    logic [3*RW-1:0]  ex[6];
    int               lats[6];
    logic [3*RW-1:0]  e;
    logic [TW-1:0]    et;
    int lat;
    bit seen;
    ops  = '{OP_SUB, OP_DOT, OP_CROSS, OP_SCALE, OP_DOT, OP_CROSS};
    av   = '{vec(5, -3, 7), vec(1, 2, 3), vec(1, 0, 0), vec(2, -3, 4),
             vec(32'h8000_0000, 32'h8000_0000, 32'h8000_0000), vec(32'h7fff_ffff, 0, 0)};
    bv   = '{vec(2, 4, -1), vec(4, 5, 6), vec(0, 1, 0), vec(-5, 0, 0),
             vec(32'h8000_0000, 32'h8000_0000, 32'h8000_0000), vec(0, 32'h8000_0000, 0)};
    ex   = '{vres(3, -7, 8), vres(32, 0, 0), vres(0, 0, 1), vres(-10, 15, -20),
             {{(2*RW){1'b0}}, 66'h0_C000_0000_0000_0000},
             vres(0, 0, -((64'sd2147483647) * (64'sd2147483648)))};
    lats = '{1, 4, 5, 4, 4, 5};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(ex[i]);
      exp_tag_q.push_back(TW'(i + 3));
      issue(ops[i], av[i], bv[i], TW'(i + 3));
      wait_out(30, lat, seen);
      e  = exp_q.pop_front();
      et = exp_tag_q.pop_front();
      checks++; if (!seen) begin errors++; $display("FAIL dir_timeout[%0d]: out_valid not seen in 30 cycles", i); end
      checks++; if (lat !== lats[i]) begin errors++; $display("FAIL dir_latency[%0d]: got %0d exp %0d", i, lat, lats[i]); end
      checks++; if (res !== e) begin errors++; $display("FAIL dir_res[%0d]: got %h exp %h", i, res, e); end
      checks++; if (tag_o !== et) begin errors++; $display("FAIL dir_tag[%0d]: got %0d exp %0d", i, tag_o, et); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [1:0] o;
    logic [3*DW-1:0] av, bv;
    logic [TW-1:0] t, et;
    logic [3*RW-1:0] e;
    int lat;
    bit seen;
    for (int n = 0; n < 40; n++) begin
      o  = 2'($urandom_range(0, 3));
      av = {rand_comp(), rand_comp(), rand_comp()};
      bv = {rand_comp(), rand_comp(), rand_comp()};
      t  = TW'($urandom);
      exp_q.push_back(ref_model(o, av, bv));
      exp_tag_q.push_back(t);
      issue(o, av, bv, t);
      wait_out(30, lat, seen);
      e  = exp_q.pop_front();
      et = exp_tag_q.pop_front();
      checks++; if (!seen || lat != exp_lat(o, NM)) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d exp %0d op %0d", n, lat, exp_lat(o, NM), o); end
      checks++; if (res !== e) begin errors++; $display("FAIL rnd_res[%0d]: op %0d got %h exp %h", n, o, res, e); end
      checks++; if (tag_o !== et) begin errors++; $display("FAIL rnd_tag[%0d]: got %0d exp %0d", n, tag_o, et); end
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rnd_retire[%0d]: in_ready %b out_valid %b exp 1 0", n, in_ready, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    logic [3*DW-1:0] av, bv;
    logic [3*RW-1:0] e;
    int lat;
    bit seen, stray;
    av = vec(7, -8, 9);
    bv = vec(-3, 11, 2);
    e  = ref_model(OP_DOT, av, bv);
    out_ready = 1'b0;
    issue(OP_DOT, av, bv, 5'd9);
    wait_out(30, lat, seen);
    checks++; if (!seen || lat != 4) begin errors++; $display("FAIL bp_latency: got %0d exp 4", lat); end
    // A request made while the result is pending must be ignored.
    op = OP_CROSS; a = vec(1, 2, 3); b = vec(4, 5, 6); tag = 5'd30; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++; if (res !== e) begin errors++; $display("FAIL bp_res[%0d]: got %h exp %h", c, res, e); end
      checks++; if (tag_o !== 5'd9) begin errors++; $display("FAIL bp_tag[%0d]: got %0d exp 9", c, tag_o); end
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hs[%0d]: out_valid %b in_ready %b exp 1 0", c, out_valid, in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bp_release: in_ready %b busy %b exp 1 0", in_ready, busy); end
    stray = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) stray = 1'b1;
    end
    checks++; if (stray) begin errors++; $display("FAIL bp_ignored_req: out_valid seen 1 exp 0"); end
  endtask

  task automatic test_reset_mid();
    logic [3*DW-1:0] av, bv;
    logic [3*RW-1:0] e;
    int lat;
    bit seen, stale;
    issue(OP_CROSS, vec(1, 0, 0), vec(0, 1, 0), 5'd21);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst: out_valid %b busy %b exp 0 0", out_valid, busy); end
    checks++; if (res !== '0 || tag_o !== '0) begin errors++; $display("FAIL mid_rst_res: res %h tag %0d exp 0 0", res, tag_o); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    stale = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    checks++; if (stale) begin errors++; $display("FAIL mid_stale: out_valid seen 1 exp 0"); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b exp 1", in_ready); end
    av = vec(-6, 13, 100);
    bv = vec(3, -2, 7);
    e  = ref_model(OP_DOT, av, bv);
    issue(OP_DOT, av, bv, 5'd12);
    wait_out(30, lat, seen);
    checks++; if (!seen || res !== e || tag_o !== 5'd12) begin errors++; $display("FAIL mid_recover: res %h tag %0d exp %h 12", res, tag_o, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_lane_configs();
    logic [3*RW-1:0] e, r6, r1;
    int lat6, lat1;
    e = vres(0, 0, 1);
    lat6 = 0; lat1 = 0; r6 = '0; r1 = '0;
    checks++; if (in_ready6 !== 1'b1 || in_ready1 !== 1'b1) begin errors++; $display("FAIL cfg_ready: %b %b exp 1 1", in_ready6, in_ready1); end
    op = OP_CROSS; a = vec(1, 0, 0); b = vec(0, 1, 0); tag = 5'd17;
    in_valid6 = 1'b1; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid6 = 1'b0; in_valid1 = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      if (out_valid6 === 1'b1 && lat6 == 0) begin lat6 = c; r6 = res6; end
      if (out_valid1 === 1'b1 && lat1 == 0) begin lat1 = c; r1 = res1; end
    end
    checks++; if (lat6 != exp_lat(OP_CROSS, 6)) begin errors++; $display("FAIL cfg6_latency: got %0d exp %0d", lat6, exp_lat(OP_CROSS, 6)); end
    checks++; if (lat1 != exp_lat(OP_CROSS, 1)) begin errors++; $display("FAIL cfg1_latency: got %0d exp %0d", lat1, exp_lat(OP_CROSS, 1)); end
    checks++; if (r6 !== e) begin errors++; $display("FAIL cfg6_res: got %h exp %h", r6, e); end
    checks++; if (r1 !== e) begin errors++; $display("FAIL cfg1_res: got %h exp %h", r1, e); end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_valid6 = 1'b0; in_valid1 = 1'b0;
    out_ready = 1'b1;
    op = OP_SUB; a = '0; b = '0; tag = '0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_lane_configs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
